// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx -- memory-mapped 8N1 UART transmitter with a byte FIFO.
//
// Registers (byte addresses on the SOC data-memory bus):
//   BASE_ADDR     TXDATA  store: push wdata[7:0]; load: last byte pushed
//   BASE_ADDR+4   STATUS  load: {27'b0, overrun, full, empty, busy, irq};
//                         a load clears the sticky overrun bit
//
// Ports:
//   clk    clock, all state changes on the rising edge
//   rst    synchronous active-high reset
//   addr   11-bit physical data address
//   wdata  store data (only [7:0] used)
//   str    store strobe, one cycle per store
//   ld     load strobe
//   rdata  load data (combinational), zero when no register is read
//   tx     serial output, idle high, registered
//   irq    high while FIFO empty and shifter idle
module mmio_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter logic [10:0] BASE_ADDR    = 11'h7F8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] addr,
  input  logic [31:0] wdata,
  input  logic        str,
  input  logic        ld,
  output logic [31:0] rdata,
  output logic        tx,
  output logic        irq
);

  localparam int          AW        = $clog2(FIFO_DEPTH);
  localparam logic [10:0] STAT_ADDR = BASE_ADDR + 11'd4;
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e        state_q;
  logic [15:0]   baud_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic          tx_q;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   count_q, count_d;
  logic          ovr_q;
  logic [7:0]    last_q;

  logic hit_tx, hit_st, full, empty, busy;
  logic wr_hit, push, pop, ovr_set, ovr_clr;

  // Upper store bits carry no meaning for this peripheral.
  logic unused_wdata;
  assign unused_wdata = ^wdata[31:8];

  assign hit_tx  = (addr == BASE_ADDR);
  assign hit_st  = (addr == STAT_ADDR);
  assign full    = (count_q == DEPTH_CNT);
  assign empty   = (count_q == '0);
  assign busy    = (state_q != IDLE);
  assign irq     = empty && !busy;

  // The shifter takes the head whenever it sits idle with data queued.
  assign pop     = (state_q == IDLE) && !empty;
  assign wr_hit  = str && hit_tx;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push    = wr_hit && (!full || pop);
  assign ovr_set = wr_hit && full && !pop;
  assign ovr_clr = ld && hit_st;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    rdata = '0;
    if (ld && hit_st)      rdata = {27'b0, ovr_q, full, empty, busy, irq};
    else if (ld && hit_tx) rdata = {24'b0, last_q};
  end

  // Storage needs no reset: pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= wdata[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovr_q   <= 1'b0;
      last_q  <= '0;
    end else begin
      if (push) begin
        wptr_q <= wptr_q + AW'(1);
        last_q <= wdata[7:0];
      end
      if (pop) rptr_q <= rptr_q + AW'(1);
      count_q <= count_d;
      // Set wins over a simultaneous read-clear.
      if (ovr_set)      ovr_q <= 1'b1;
      else if (ovr_clr) ovr_q <= 1'b0;
    end
  end

  // tx is loaded on the same edge as each state change so the line
  // switches exactly at the start of each bit period.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          tx_q <= 1'b1;
          if (!empty) begin
            shift_q <= mem_q[rptr_q];
            baud_q  <= '0;
            tx_q    <= 1'b0;
            state_q <= START;
          end
        end
        START: begin
          if (baud_q == BAUD_LAST) begin
            baud_q  <= '0;
            bit_q   <= '0;
            tx_q    <= shift_q[0];
            state_q <= DATA;
          end else begin
            baud_q <= baud_q + 16'd1;
          end
        end
        DATA: begin
          if (baud_q == BAUD_LAST) begin
            baud_q <= '0;
            if (bit_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= STOP;
            end else begin
              bit_q   <= bit_q + 3'd1;
              shift_q <= {1'b0, shift_q[7:1]};
              tx_q    <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q + 16'd1;
          end
        end
        STOP: begin
          if (baud_q == BAUD_LAST) begin
            baud_q  <= '0;
            state_q <= IDLE;
          end else begin
            baud_q <= baud_q + 16'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx = tx_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx (CLKS_PER_BIT=4, FIFO_DEPTH=8).
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_mmio_uart_tx;

  localparam logic [10:0] TXD = 11'h7F8;
  localparam logic [10:0] STA = 11'h7FC;
  // STATUS = {overrun, full, empty, busy, irq}
  localparam logic [31:0] ST_RESET = 32'h05;
  localparam logic [31:0] ST_FULL  = 32'h0A;
  localparam logic [31:0] ST_OVR   = 32'h1A;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        str = 1'b0;
  logic        ld = 1'b0;
  logic [31:0] rdata;
  logic        tx;
  logic        irq;

  int errors = 0;
  int checks = 0;

  mmio_uart_tx #(
    .CLKS_PER_BIT(4),
    .FIFO_DEPTH  (8),
    .BASE_ADDR   (11'h7F8)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .addr (addr),
    .wdata(wdata),
    .str  (str),
    .ld   (ld),
    .rdata(rdata),
    .tx   (tx),
    .irq  (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Caller sits on the negedge of frame cycle start_i with ld=1, addr=STA.
  // Returns on the negedge of the idle cycle after the frame.
  task automatic expect_frame(input logic [7:0] b, input int start_i);
    logic exp_tx;
    for (int i = start_i; i < 40; i++) begin
      if (i > start_i) @(negedge clk);
      #1;
      if (i < 4)       exp_tx = 1'b0;
      else if (i < 36) exp_tx = b[(i-4)/4];
      else             exp_tx = 1'b1;
      check($sformatf("tx[%02h]c%0d", b, i), tx, exp_tx);
      check($sformatf("busy[%02h]c%0d", b, i), rdata[1], 1'b1);
    end
    @(negedge clk); #1;
    check("gap_tx", tx, 1'b1);
    check("gap_busy", rdata[1], 1'b0);
  endtask

  // n back-to-back stores of base+1..base+n with junk in the upper bits.
  task automatic store_burst(input logic [7:0] base, input int n);
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      str = 1'b1; ld = 1'b0; addr = TXD;
      wdata = {24'hABCDEF, base + 8'(k)};
    end
  endtask

  task automatic read_status(input string tag, input logic [31:0] exp);
    ld = 1'b1; addr = STA; #1;
    check(tag, rdata, exp);
  endtask

  initial begin
    // Reset state
    ld = 1'b1; addr = STA;
    repeat (3) @(negedge clk);
    #1;
    check("rst_tx", tx, 1'b1);
    check("rst_irq", irq, 1'b1);
    check("rst_status", rdata, ST_RESET);
    addr = TXD; #1;
    check("rst_txdata", rdata, 32'h0);
    rst = 1'b0;

    // Single frame 0xA5
    store_burst(8'hA4, 1);
    @(negedge clk); str = 1'b0;
    read_status("a5_status_queued", 32'h0);
    addr = TXD; #1;
    check("a5_txdata", rdata, 32'hA5);
    @(negedge clk); addr = STA;
    expect_frame(8'hA5, 0);
    check("a5_irq_after", irq, 1'b1);
    check("a5_status_after", rdata, ST_RESET);

    // Nine back-to-back stores: one to shifter, eight fill FIFO
    store_burst(8'h00, 9);
    @(negedge clk); str = 1'b0;
    read_status("b2b_full", ST_FULL);
    expect_frame(8'h01, 7);
    for (int k = 2; k <= 9; k++) begin
      @(negedge clk);
      expect_frame(8'(k), 0);
    end
    read_status("b2b_drained", ST_RESET);

    // Overrun: tenth store while full with no pop
    store_burst(8'h10, 10);
    @(negedge clk); str = 1'b0;
    read_status("ovr_set", ST_OVR);
    @(negedge clk);
    read_status("ovr_cleared", ST_FULL);
    expect_frame(8'h11, 9);
    for (int k = 2; k <= 9; k++) begin
      @(negedge clk);
      expect_frame(8'h10 + 8'(k), 0);
    end
    read_status("ovr_drained", ST_RESET);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk); #1;
      check("ovr_no_extra_frame", tx, 1'b1);
    end
    addr = TXD; #1;
    check("ovr_last_byte", rdata, 32'h19);

    // Store to full FIFO on the idle pop edge
    addr = STA;
    store_burst(8'h20, 9);
    @(negedge clk); str = 1'b0;
    read_status("pop_edge_full", ST_FULL);
    expect_frame(8'h21, 7);
    str = 1'b1; addr = TXD; wdata = 32'h0000_002A;
    @(negedge clk); str = 1'b0;
    read_status("pop_edge_accept", ST_FULL);
    expect_frame(8'h22, 0);
    for (int k = 3; k <= 10; k++) begin
      @(negedge clk);
      expect_frame(8'h20 + 8'(k), 0);
    end
    read_status("pop_edge_drained", ST_RESET);

    // Reset mid-frame (bit 3 of 0x31) with three bytes queued
    store_burst(8'h30, 4);
    @(negedge clk); str = 1'b0;
    read_status("midrst_queued", 32'h02);
    repeat (15) @(negedge clk);
    #1;
    check("midrst_bit3", tx, 1'b0);
    rst = 1'b1; str = 1'b1; ld = 1'b0; addr = TXD; wdata = 32'h77;
    @(negedge clk);
    rst = 1'b0; str = 1'b0;
    read_status("midrst_status", ST_RESET);
    check("midrst_tx", tx, 1'b1);
    addr = TXD; #1;
    check("midrst_txdata", rdata, 32'h0);
    addr = STA;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk); #1;
      check("midrst_quiet", tx, 1'b1);
    end
    read_status("midrst_status_late", ST_RESET);

    // Unmapped addresses and store to STATUS
    ld = 1'b1; addr = 11'h7F0; #1;
    check("unmapped_7f0", rdata, 32'h0);
    addr = 11'h000; #1;
    check("unmapped_000", rdata, 32'h0);
    ld = 1'b0;
    @(negedge clk); str = 1'b1; addr = 11'h7F0; wdata = 32'h55;
    @(negedge clk); addr = 11'h000;
    @(negedge clk); addr = STA;
    @(negedge clk); str = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); #1;
      check("unmapped_tx", tx, 1'b1);
    end
    read_status("unmapped_status", ST_RESET);
    addr = TXD; #1;
    check("unmapped_txdata", rdata, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
